// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART transmitter between N_REQ word producers.
// Optional UART_TX_ARB_HEADER_EN: prefix each word with header byte 8'hA0 | winner[3:0].
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_BITS = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*DATA_BITS-1:0] i_data,
  output logic [N_REQ-1:0]           o_ack,
  output logic [N_REQ-1:0]           o_grant,
  output logic                       o_tx_start,
  output logic [7:0]                 o_tx_data,
  input  logic                       i_tx_done,
  output logic                       o_busy
);

  localparam int BYTES = DATA_BITS / 8;
`ifdef UART_TX_ARB_HEADER_EN
  localparam int HDR_OFS = 1;
`else
  localparam int HDR_OFS = 0;
`endif
  localparam int LAST   = BYTES - 1 + HDR_OFS;
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = (LAST > 0) ? $clog2(LAST + 1) : 1;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

  state_t                               state_q, state_d;
  logic [N_REQ-1:0][BYTES-1:0][7:0]     words;
  logic [BYTES-1:0][7:0]                shadow_q;
  logic [IDX_W-1:0]                     ptr_q, win_q, arb_idx, cand;
  logic                                 arb_found;
  logic [CNT_W-1:0]                     cnt_q;
  logic [N_REQ-1:0]                     grant_q;
  logic [7:0]                           txd_q, first_byte;
  logic [BIDX_W-1:0]                    nxt_bidx;
  logic                                 last_byte;

  assign words     = i_data;
  assign last_byte = (cnt_q == CNT_W'(LAST));
  // Byte index of the next data byte; the header slot shifts data by one count.
  assign nxt_bidx  = BIDX_W'(int'(cnt_q) + 1 - HDR_OFS);

`ifdef UART_TX_ARB_HEADER_EN
  assign first_byte = 8'hA0 | 8'(arb_idx);
`else
  assign first_byte = words[arb_idx][0];
`endif

  // Rotating priority search starting at ptr_q.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % N_REQ);
      if (!arb_found && i_req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_found) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (i_tx_done) state_d = last_byte ? ACK : START;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr_q    <= '0;
      win_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      grant_q  <= '0;
      txd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (arb_found) begin
          grant_q  <= N_REQ'(1) << arb_idx;
          win_q    <= arb_idx;
          shadow_q <= words[arb_idx];
          cnt_q    <= '0;
          txd_q    <= first_byte;
        end
        WAIT: if (i_tx_done && !last_byte) begin
          cnt_q <= cnt_q + 1'b1;
          txd_q <= shadow_q[nxt_bidx];
        end
        ACK: begin
          grant_q <= '0;
          ptr_q   <= (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_grant    = grant_q;
  assign o_ack      = (state_q == ACK) ? grant_q : '0;
  assign o_tx_start = (state_q == START);
  assign o_tx_data  = txd_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a word/byte-queue model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int NB = DW / 8;
`ifdef UART_TX_ARB_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic                  i_clk = 1'b0;
  logic                  i_reset_n = 1'b1;
  logic [N-1:0]          i_req = '0;
  logic [N-1:0][DW-1:0]  i_data = '0;
  logic                  i_tx_done = 1'b0;
  logic [N-1:0]          o_ack, o_grant;
  logic                  o_tx_start, o_busy;
  logic [7:0]            o_tx_data;

  uart_tx_arbiter #(.N_REQ(N), .DATA_BITS(DW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req(i_req), .i_data(i_data),
    .o_ack(o_ack), .o_grant(o_grant), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_done(i_tx_done), .o_busy(o_busy));

  always #5 i_clk = ~i_clk;

  int n_cmp = 0, n_err = 0;

  // model: owner of the line, bytes still to send, and which event is pending
  int         m_ptr, m_owner;
  logic [7:0] m_q[$];
  logic [7:0] m_txd;
  bit         m_start, m_air, m_ackn;

  int d_fixed = 0, spur = 0, rnd = 0, rcnt = 0;
  logic [7:0]   cap_b[$];
  logic [N-1:0] cap_ack[$];
  int           cap_g[$];
  logic [N-1:0] prev_grant = '0;

  function automatic logic [1:0] ix(int k);
    return 2'(k);
  endfunction

  function automatic logic [7:0] byte_of(logic [31:0] w, int b);
    return 8'(w >> (8 * b));
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_q.delete();
    m_start = 0; m_air = 0; m_ackn = 0; m_txd = '0;
  endtask

  task automatic model_step();
    if (m_ackn) begin
      m_ptr = (m_owner + 1) % N; m_owner = -1; m_ackn = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (i_req[ix(k)]) begin
          m_owner = k;
          m_q.delete();
          if (HDR) m_q.push_back(8'hA0 | 8'(k));
          for (int b = 0; b < NB; b++) m_q.push_back(byte_of(i_data[ix(k)], b));
          m_txd = m_q[0];
          m_start = 1;
          break;
        end
      end
    end else if (m_start) begin
      m_start = 0; m_air = 1;
    end else if (m_air && i_tx_done) begin
      void'(m_q.pop_front());
      m_air = 0;
      if (m_q.size() == 0) m_ackn = 1;
      else begin m_txd = m_q[0]; m_start = 1; end
    end
  endtask

  // UART responder, spurious done pulses and requester behaviour
  task automatic drive();
    i_tx_done = 1'b0;
    if (m_start) rcnt = (d_fixed > 0) ? d_fixed : int'($urandom_range(1, 6));
    else if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) i_tx_done = 1'b1;
    end
    if (!m_air && (spur == 2 || (spur == 1 && $urandom_range(0, 3) == 0))) i_tx_done = 1'b1;
    if (m_ackn) i_data[ix(m_owner)] = $urandom;
    if (rnd != 0)
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) i_data[ix(k)] = $urandom;
        if ($urandom_range(0, 7) == 0) i_req[ix(k)] = ~i_req[ix(k)];
      end
  endtask

  task automatic check();
    logic [N-1:0] eg, ea;
    int g;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    ea = m_ackn ? eg : 4'b0000;
    n_cmp++;
    if ({o_grant, o_ack, o_tx_start, o_busy, o_tx_data} !==
        {eg, ea, m_start, (m_owner >= 0), m_txd}) begin
      n_err++;
      $display("FAIL cycle @%0t: grant %b/%b ack %b/%b start %b/%b busy %b/%b data %h/%h (got/exp)",
               $time, o_grant, eg, o_ack, ea, o_tx_start, m_start, o_busy, (m_owner >= 0), o_tx_data, m_txd);
    end
    if (o_tx_start) cap_b.push_back(o_tx_data);
    if (o_ack != 0) cap_ack.push_back(o_ack);
    if (o_grant != 0 && prev_grant == 0) begin
      g = -1;
      for (int j = 0; j < N; j++) if (o_grant[ix(j)]) g = j;
      cap_g.push_back(g);
    end
    prev_grant = o_grant;
  endtask

  task automatic cycle();
    @(posedge i_clk);
    if (i_reset_n) model_step();
    #1 drive();
    @(negedge i_clk);
    check();
  endtask

  task automatic cycles(int n);
    repeat (n) cycle();
  endtask

  task automatic clear_cap();
    cap_b.delete(); cap_ack.delete(); cap_g.delete();
  endtask

  task automatic apply_reset();
    #2 i_reset_n = 1'b0;
    model_reset();
    #1 chk("reset_async_outputs", int'({o_grant, o_ack, o_tx_start, o_busy, o_tx_data}), 0);
    i_req = '0;
    cycles(2);
    i_reset_n = 1'b1;
  endtask

  task automatic wait_ack(string nm, int budget);
    int n0, t;
    n0 = cap_ack.size(); t = 0;
    while (cap_ack.size() == n0 && t < budget) begin cycle(); t++; end
    chk({nm, "_ack_seen"}, int'(cap_ack.size() > n0), 1);
  endtask

  task automatic wait_grant(string nm, int budget);
    int t;
    t = 0;
    while (o_grant == 0 && t < budget) begin cycle(); t++; end
    chk({nm, "_grant_seen"}, int'(o_grant != 0), 1);
  endtask

  task automatic chk_bytes(string nm, logic [7:0] e[$]);
    chk({nm, "_nbytes"}, cap_b.size(), e.size());
    for (int i = 0; i < e.size() && i < cap_b.size(); i++)
      chk({nm, "_byte"}, int'(cap_b[i]), int'(e[i]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e[$];
    int eg[5];
    int ea[5];
    eg = '{0, 1, 2, 3, 0};
    ea = '{1, 2, 4, 8, 1};
    model_reset();
    #1 i_reset_n = 1'b0;
    #2 chk("reset_power_on", int'({o_grant, o_ack, o_tx_start, o_busy, o_tx_data}), 0);
    cycles(2);
    i_reset_n = 1'b1;

    // single requester, slow UART
    d_fixed = 20; clear_cap();
    i_data[0] = 32'h44332211; i_req = 4'b0001;
    wait_ack("t1", 200);
    i_req = '0;
    cycles(5);
    e = '{8'h11, 8'h22, 8'h33, 8'h44};
    if (HDR) e.push_front(8'hA0);
    chk_bytes("t1", e);
    chk("t1_nacks", cap_ack.size(), 1);
    chk("t1_ack_val", int'(cap_ack[0]), 1);

    // all requesting: round-robin order
    apply_reset();
    d_fixed = 2; clear_cap();
    for (int k = 0; k < N; k++) i_data[ix(k)] = $urandom;
    i_req = 4'b1111;
    cycles(100);
    i_req = '0;
    cycles(60);
    for (int i = 0; i < 5; i++) begin
      chk("t2_grant_order", cap_g[i], eg[i]);
      chk("t2_ack_order", int'(cap_ack[i]), ea[i]);
    end
    chk("t2_one_ack_per_word", cap_ack.size(), cap_g.size());

    // snapshot: data change and req drop after grant
    apply_reset();
    d_fixed = 3; clear_cap();
    i_data[0] = 32'h44332211; i_req = 4'b0001;
    wait_grant("t3", 10);
    i_data[0] = 32'hDEADBEEF; i_req = '0;
    wait_ack("t3", 100);
    cycles(5);
    chk_bytes("t3", e);
    chk("t3_nacks", cap_ack.size(), 1);
    chk("t3_ack_val", int'(cap_ack[0]), 1);

    // reset mid-word with ptr=2
    apply_reset();
    d_fixed = 10;
    i_data[1] = $urandom; i_req = 4'b0010;
    wait_ack("t4_setup", 100);
    i_req = '0;
    cycles(3);
    clear_cap();
    i_data[2] = $urandom; i_req = 4'b0100;
    for (int t = 0; t < 200 && cap_b.size() < 3 + int'(HDR); t++) cycle();
    chk("t4_reached_byte2", cap_b.size(), 3 + int'(HDR));
    cycles(3);
    apply_reset();
    cycles(8);
    chk("t4_no_ack", cap_ack.size(), 0);
    clear_cap();
    i_req = 4'b0101;
    wait_grant("t4", 5);
    chk("t4_first_grant", cap_g[0], 0);
    i_req = '0;
    wait_ack("t4", 200);
    cycles(3);

    // done pulses in IDLE, START and ACK
    apply_reset();
    spur = 2; d_fixed = 3; clear_cap();
    cycles(3);
    i_data[0] = 32'h44332211; i_req = 4'b0001;
    wait_grant("t5", 5);
    i_req = '0;
    wait_ack("t5", 100);
    cycles(4);
    spur = 0;
    chk_bytes("t5", e);
    chk("t5_ack_val", int'(cap_ack[0]), 1);

    // requester 3 word (header 8'hA3 when enabled)
    apply_reset();
    d_fixed = 4; clear_cap();
    i_data[3] = 32'h0A0B0C0D; i_req = 4'b1000;
    wait_grant("t6", 5);
    i_req = '0;
    wait_ack("t6", 100);
    cycles(3);
    e = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};
    if (HDR) e.push_front(8'hA3);
    chk_bytes("t6", e);
    chk("t6_ack_val", int'(cap_ack[0]), 8);

    // randomized traffic with a reset in the middle
    apply_reset();
    d_fixed = 0; spur = 1; rnd = 1; clear_cap();
    cycles(2000);
    apply_reset();
    cycles(2000);
    rnd = 0; spur = 0; i_req = '0;
    cycles(60);
    chk("rnd_progress", int'(cap_ack.size() > 20), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
